// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared widths, types and word-select helper for the AES-128 stream shell
package aes_stream_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int AES_128_LATENCY = 21;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  // Word 0 is the most significant word of the block.
  function automatic word_t block_word(input block_t blk, input logic [1:0] idx);
    word_t w;
    w = blk[WORD_W-1:0];
    case (idx)
      2'd0:    w = blk[4*WORD_W-1:3*WORD_W];
      2'd1:    w = blk[3*WORD_W-1:2*WORD_W];
      2'd2:    w = blk[2*WORD_W-1:WORD_W];
      default: w = blk[WORD_W-1:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// rtl/aes_blk_fifo.sv - 128-bit block FIFO buffering finished ciphertext
module aes_blk_fifo
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [BLOCK_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [BLOCK_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [BLOCK_W-1:0] mem [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head     = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/aes_128_stream_io.sv
// rtl/aes_128_stream_io.sv - word-serial shell feeding a fixed-latency AES-128 core, credit-protected output buffer
module aes_128_stream_io
  import aes_stream_pkg::*;
#(
  parameter int LATENCY    = AES_128_LATENCY,
  parameter int OBUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] core_state,
  output logic [BLOCK_W-1:0] core_key,
  input  logic [BLOCK_W-1:0] core_out,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int            CW         = $clog2(OBUF_DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OBUF_DEPTH);

  logic [1:0]          in_cnt_q, in_cnt_d;
  logic [3*WORD_W-1:0] staging_q, staging_d;
  logic [BLOCK_W-1:0]  key_q, key_d;
  logic [BLOCK_W-1:0]  core_state_q, core_state_d;
  logic                issue_q, issue_d;
  logic [LATENCY-1:0]  valid_pipe_q, valid_pipe_d;
  logic [1:0]          out_cnt_q, out_cnt_d;
  logic [CW-1:0]       credits_q, credits_d;

  logic               in_fire, word3_fire, out_fire;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BLOCK_W-1:0] fifo_head;

  always_comb begin
    // Credits are checked on the registered count, so a same-cycle pop never frees a slot early.
    in_ready   = (in_cnt_q != 2'd3) || (credits_q < CREDIT_MAX);
    key_ready  = (credits_q == '0) && (in_cnt_q == 2'd0);
    in_fire    = in_valid && in_ready;
    word3_fire = in_fire && (in_cnt_q == 2'd3);

    out_valid  = !fifo_empty;
    out_data   = fifo_empty ? '0 : block_word(fifo_head, out_cnt_q);
    out_fire   = out_valid && out_ready;
    fifo_pop   = out_fire && (out_cnt_q == 2'd3);
    fifo_push  = valid_pipe_q[LATENCY-1];

    core_state = core_state_q;
    core_key   = key_q;

    key_d        = key_q;
    in_cnt_d     = in_cnt_q;
    staging_d    = staging_q;
    core_state_d = core_state_q;
    out_cnt_d    = out_cnt_q;
    credits_d    = credits_q;

    if (key_valid && key_ready) key_d = key_in;

    if (in_fire) begin
      in_cnt_d = in_cnt_q + 2'd1;
      if (in_cnt_q == 2'd3) core_state_d = {staging_q, in_data};
      else                  staging_d    = {staging_q[2*WORD_W-1:0], in_data};
    end

    issue_d      = word3_fire;
    valid_pipe_d = {valid_pipe_q[LATENCY-2:0], issue_q};

    if (out_fire) out_cnt_d = out_cnt_q + 2'd1;

    case ({word3_fire, fifo_pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q        <= '0;
      in_cnt_q     <= '0;
      staging_q    <= '0;
      core_state_q <= '0;
      issue_q      <= 1'b0;
      valid_pipe_q <= '0;
      out_cnt_q    <= '0;
      credits_q    <= '0;
    end else begin
      key_q        <= key_d;
      in_cnt_q     <= in_cnt_d;
      staging_q    <= staging_d;
      core_state_q <= core_state_d;
      issue_q      <= issue_d;
      valid_pipe_q <= valid_pipe_d;
      out_cnt_q    <= out_cnt_d;
      credits_q    <= credits_d;
    end
  end

  aes_blk_fifo #(.DEPTH(OBUF_DEPTH)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (core_out),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // The core cannot stall, so a result arriving at a full buffer would be lost.
  obuf_overflow_a: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_aes_128_stream_io.sv
// tb/tb_aes_128_stream_io.sv - directed bench for aes_128_stream_io with a behavioural pipelined AES-128 core
module tb_aes_128_stream_io;

  localparam int LAT   = 9;
  localparam int DEPTH = 4;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid, key_ready;
  logic [31:0]  in_data;
  logic         in_valid, in_ready;
  logic [127:0] core_state, core_key, core_out;
  logic [31:0]  out_data;
  logic         out_valid, out_ready;
  logic         ready_cmd = 1'b0, rand_mode = 1'b0, rnd_ready = 1'b0;

  int passed = 0, failed = 0, total = 0, stall_viol = 0;
  logic [31:0]  got [$];
  logic [127:0] exp_q [$];
  logic         prev_stall = 1'b0;
  logic [31:0]  prev_data = '0;
  logic [7:0]   sbox [256];
  logic [127:0] core_pipe [LAT];

  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rnd_ready : ready_cmd;
  always @(negedge clk) rnd_ready <= 1'($urandom_range(0, 1));

  aes_128_stream_io #(.LATENCY(LAT), .OBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [127:0] s, t;
    logic [7:0]   rc, a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) s[127-8*b -: 8] = sbox[s[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[127-8*(c*4+rr) -: 8] = s[127-8*(((c+rr)%4)*4+rr) -: 8];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {xt(a0)^xt(a1)^a1^a2^a3, a0^xt(a1)^xt(a2)^a2^a3,
                               a0^a1^xt(a2)^xt(a3)^a3, xt(a0)^a0^a1^a2^xt(a3)};
        end
      end
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // Stand-in for the fully pipelined, non-resettable core.
  always @(posedge clk) begin
    core_pipe[0] <= aes_enc(core_state, core_key);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-1];

  always @(posedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, output int waits);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    waits    = 0;
    while (!in_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("in_ready timeout", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] b, output int drops);
    int w;
    drops = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(b[127-32*i -: 32], w);
      drops += w;
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_in = k; key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int k, n;
    logic [127:0] blk;
    k = 0;
    n = exp_q.size();
    while (got.size() < 4*n && k < 800) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
    check({tag, " word count"}, 128'(got.size()), 128'(4*n));
    for (int b = 0; b < n; b++) begin
      blk = '0;
      if (got.size() >= 4*b+4) blk = {got[4*b], got[4*b+1], got[4*b+2], got[4*b+3]};
      check(tag, blk, exp_q[b]);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] b;
    int d, n, drops;
    logic seen;
    rst = 1'b1; key_in = '0; key_valid = 1'b0; in_data = '0; in_valid = 1'b0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    repeat (3) @(negedge clk);
    check("reset in_ready", {127'b0, in_ready}, 128'd1);
    check("reset key_ready", {127'b0, key_ready}, 128'd1);
    check("reset out_valid", {127'b0, out_valid}, 128'd0);
    check("reset out_data", {96'b0, out_data}, 128'd0);
    check("reset core_state", core_state, 128'd0);
    check("reset core_key", core_key, 128'd0);
    rst = 1'b0;

    // FIPS-197 C.1 with first-valid latency
    load_key(KEY1);
    check("key load", core_key, KEY1);
    ready_cmd = 1'b1;
    send_block(PT1, drops);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = out_valid;
    end
    check("first out_valid latency", 128'(n), 128'(LAT + 2));
    repeat (8) @(negedge clk);
    check("c1 word count", 128'(got.size()), 128'd4);
    check("c1 word0", {96'b0, got.size() > 0 ? got[0] : 32'h0}, 128'h69c4e0d8);
    check("c1 word1", {96'b0, got.size() > 1 ? got[1] : 32'h0}, 128'h6a7b0430);
    check("c1 word2", {96'b0, got.size() > 2 ? got[2] : 32'h0}, 128'hd8cdb780);
    check("c1 word3", {96'b0, got.size() > 3 ? got[3] : 32'h0}, 128'h70b4c55a);
    got.delete();

    // Back-to-back blocks at full rate
    n = 0;
    for (int i = 0; i < 8; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(aes_enc(b, KEY1));
      send_block(b, drops);
      n += drops;
    end
    check("b2b in_ready drops", 128'(n), 128'd0);
    drain_and_check("b2b block");

    // Backpressure: four blocks fill the credits, the fifth waits at word 3
    ready_cmd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(aes_enc(b, KEY1));
      send_block(b, drops);
    end
    b = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(aes_enc(b, KEY1));
    for (int i = 0; i < 3; i++) send_word(b[127-32*i -: 32], d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b[31:0];
    repeat (LAT + 8) @(negedge clk);
    check("bp in_ready at word3", {127'b0, in_ready}, 128'd0);
    check("bp credits_used", 128'(dut.credits_q), 128'd4);
    check("bp out_valid held", {127'b0, out_valid}, 128'd1);
    ready_cmd = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp word3 released", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain_and_check("bp block");

    // Key gating mid-block, then a successful reload
    b = PT2;
    send_word(b[127:96], d);
    send_word(b[95:64], d);
    @(negedge clk);
    key_in = KEY2; key_valid = 1'b1;
    check("key_ready mid-block", {127'b0, key_ready}, 128'd0);
    @(posedge clk);
    #1 key_valid = 1'b0;
    check("key ignored mid-block", core_key, KEY1);
    send_word(b[63:32], d);
    send_word(b[31:0], d);
    exp_q.push_back(aes_enc(PT2, KEY1));
    drain_and_check("old key block");
    @(negedge clk);
    check("key_ready drained", {127'b0, key_ready}, 128'd1);
    load_key(KEY2);
    check("new key loaded", core_key, KEY2);
    send_block(PT2, drops);
    exp_q.push_back(128'h3925841d02dc09fbdc118597196a0b32);
    drain_and_check("new key block");

    // Reset mid-flight with a partial block pending
    send_block(PT1, drops);
    send_word(32'hdeadbeef, d);
    send_word(32'hcafef00d, d);
    repeat (LAT/2 - 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid reset out_valid", {127'b0, out_valid}, 128'd0);
    check("mid reset key", core_key, 128'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (LAT + 8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("stale result suppressed", {127'b0, seen}, 128'd0);
    check("no words after reset", 128'(got.size()), 128'd0);
    got.delete();
    load_key(KEY2);
    send_block(PT2, drops);
    exp_q.push_back(128'h3925841d02dc09fbdc118597196a0b32);
    drain_and_check("post reset block");

    // Random output stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(aes_enc(b, KEY2));
      send_block(b, drops);
    end
    drain_and_check("stall block");
    rand_mode = 1'b0;
    check("stall stability violations", 128'(stall_viol), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
